imem_loader: RTL and testbench

Write-side counterpart of the instruction memory. Receives a byte stream from a host link and assembles it into little-endian 32-bit words. Issues one word-aligned write per word into the instruction memory array at consecutive addresses starting at 0, and reports completion or error. While Busy is high the CPU is held stalled so no fetch races a write.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a host byte stream into little-endian 32-bit words
// and writes them to the instruction memory at consecutive word addresses
// from 0. Busy stalls the CPU while a session is in progress.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_in_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  wr_enable_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [31:0]           wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           asm_q, asm_d;      // lanes 0..2 of the word in flight
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [15:0]           words_q, words_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = byte_ready_o && byte_valid_i;
  assign len_full  = {byte_in_i, count_q[7:0]};
  assign last_word = (idx_q + 16'd1) == count_q;

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
                  if (len_full == 16'd0)                      state_d = S_DONE;
                  else if (32'(len_full) > 32'(DEPTH_WORDS))  state_d = S_ERR;
                  else                                        state_d = S_DATA;
                end
      S_DATA:   if (xfer && lane_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    if (start_i) state_d = S_LEN_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    byte_ready_o = 1'b0;
    wr_enable_o  = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_WRITE: begin
        wr_enable_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_DONE:  done_o  = 1'b1;
      S_ERR:   error_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: length capture, byte lane packing, write staging.
  // The write address/data are registered on the 4th byte so they are
  // stable during WRITE and hold afterwards.
  always_comb begin
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    case (state_q)
      S_LEN_LO: if (xfer) count_d[7:0] = byte_in_i;
      S_LEN_HI: if (xfer) begin
                  count_d[15:8] = byte_in_i;
                  idx_d         = 16'd0;
                  lane_d        = 2'd0;
                  if (len_full == 16'd0) words_d = 16'd0;
                end
      S_DATA:   if (xfer) begin
                  lane_d = lane_q + 2'd1;
                  case (lane_q)
                    2'd0: asm_d[7:0]   = byte_in_i;
                    2'd1: asm_d[15:8]  = byte_in_i;
                    2'd2: asm_d[23:16] = byte_in_i;
                    default: begin
                      data_d = {byte_in_i, asm_q};
                      addr_d = ADDR_WIDTH'({idx_q, 2'b00});
                    end
                  endcase
                end
      S_WRITE:  begin
                  idx_d  = idx_q + 16'd1;
                  lane_d = 2'd0;
                  if (last_word) words_d = count_q;
                end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
    end
  end

  assign wr_address_o   = addr_q;
  assign wr_data_o      = data_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready, wr_enable, busy, done, error;
  logic [AW-1:0] wr_address;
  logic [31:0]   wr_data;
  logic [15:0]   words_loaded;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .byte_in_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready), .wr_enable_o(wr_enable),
    .wr_address_o(wr_address), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .error_o(error),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: what the memory side sees, sampled mid-cycle
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] wq[$];          // words the next session sends
  int first_wr_cyc, last_wr_cyc, done_cyc, done_cnt, ready_in_write, xfer_cyc;
  logic [15:0] done_words;
  logic        done_busy;

  always @(negedge clk) begin
    if (wr_enable) begin
      if (obs_addr.size() == 0) first_wr_cyc = cyc;
      obs_addr.push_back(wr_address);
      obs_data.push_back(wr_data);
      last_wr_cyc = cyc;
      if (byte_ready) ready_in_write++;
    end
    if (done) begin
      done_cnt++;
      done_words = words_loaded;
      done_cyc   = cyc;
      done_busy  = busy;
    end
  end

  task automatic clr_mon();
    obs_addr.delete(); obs_data.delete();
    done_cnt = 0; ready_in_write = 0; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Offer one byte, optionally after idle gap cycles; returns after the
  // edge on which it transferred. byte_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin byte_valid = 1'b0; tick(); end
    byte_valid = 1'b1; byte_in = b;
    for (int t = 0; t < 40; t++) begin
      if (byte_ready) begin xfer_cyc = cyc; tick(); ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_byte timeout: byte %02h never accepted (ready=%b)", b, byte_ready); end
  endtask

  // One session: count n, data from wq. Model: n==0 -> done with 0 words;
  // n>DEPTH -> error, no writes; else word i lands at 4*i little-endian.
  task automatic run_session(input int n, input int max_gap, input int mid_start_at, input int tail);
    int nexp, k;
    logic [31:0] w;
    clr_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin errors++;
      $display("FAIL start_taken: busy=%b error=%b want busy=1 error=0", busy, error); end
    send_byte(n[7:0], $urandom_range(max_gap, 0));
    send_byte(n[15:8], $urandom_range(max_gap, 0));
    nexp = (n >= 1 && n <= DEPTH) ? n : 0;
    k = 0;
    for (int i = 0; i < nexp; i++) begin
      w = wq[i];
      for (int j = 0; j < 4; j++) begin
        if (k == mid_start_at) start = 1'b1;
        send_byte(w[8*j +: 8], $urandom_range(max_gap, 0));
        start = 1'b0;
        k++;
      end
    end
    if (tail >= 0) begin byte_in = tail[7:0]; byte_valid = 1'b1; end
    else byte_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (done_cnt > 0 || error) break;
      tick();
    end
    if (n > DEPTH) begin
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || obs_addr.size() != 0 || done_cnt != 0) begin
        errors++;
        $display("FAIL overflow_err: error=%b busy=%b ready=%b writes=%0d dones=%0d want 1 0 0 0 0",
                 error, busy, byte_ready, obs_addr.size(), done_cnt);
      end
    end else begin
      checks++;
      if (done_cnt != 1 || done_words !== n[15:0] || done_busy !== 1'b0) begin errors++;
        $display("FAIL done_pulse: dones=%0d words=%0d busy=%b want 1 %0d 0", done_cnt, done_words, done_busy, n); end
      checks++;
      if (obs_addr.size() != nexp) begin errors++;
        $display("FAIL write_count: got %0d want %0d", obs_addr.size(), nexp); end
      for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== 32'(i * 4) || obs_data[i] !== wq[i]) begin errors++;
          $display("FAIL write[%0d]: got (%h,%h) want (%h,%h)", i, obs_addr[i], obs_data[i], 32'(i*4), wq[i]); end
      end
      checks++;
      if (nexp > 0 && (last_wr_cyc != xfer_cyc + 1 || done_cyc != last_wr_cyc + 1)) begin errors++;
        $display("FAIL latency: last byte cyc %0d write cyc %0d done cyc %0d", xfer_cyc, last_wr_cyc, done_cyc); end
      else if (nexp == 0 && done_cyc != xfer_cyc + 1) begin errors++;
        $display("FAIL zero_latency: len byte cyc %0d done cyc %0d", xfer_cyc, done_cyc); end
      checks++;
      if (ready_in_write != 0) begin errors++;
        $display("FAIL ready_in_write: ready high in %0d write cycles, want 0", ready_in_write); end
      tick();
      checks++;
      if (busy !== 1'b0 || error !== 1'b0) begin errors++;
        $display("FAIL idle_after: busy=%b error=%b want 0 0", busy, error); end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({byte_ready, wr_enable, wr_address, wr_data, busy, done, error, words_loaded} !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b words=%0d want all 0",
               name, byte_ready, wr_enable, wr_address, wr_data, busy, done, error, words_loaded);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    tick(); tick();
    check_zero("reset_state");
    reset = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h5A;
    tick(); tick();
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL idle_ignores_bytes: ready=%b busy=%b want 0 0", byte_ready, busy); end
    byte_valid = 1'b0;
  endtask

  task automatic test_two_words();
    wq = '{32'h12345678, 32'hDEADBEEF};
    run_session(2, 0, -1, -1);
  endtask

  task automatic test_zero_count();
    run_session(0, 1, -1, -1);
  endtask

  task automatic test_overflow();
    run_session(1025, 0, -1, -1);
    repeat (3) tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || obs_addr.size() != 0) begin errors++;
      $display("FAIL error_sticky: error=%b busy=%b writes=%0d want 1 0 0", error, busy, obs_addr.size()); end
    wq = '{32'h00000013};
    run_session(1, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    wq = '{32'hDDCCBBAA};
    run_session(1, 0, -1, 8'h11);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL held_byte_idle: ready=%b busy=%b want 0 0", byte_ready, busy); end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h99, 0); send_byte(8'h88, 0);
    byte_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check_zero("reset_mid_load");
    wq = '{$urandom, $urandom};
    run_session(2, 1, -1, -1);
  endtask

  task automatic test_start_mid_data();
    wq = '{$urandom, $urandom, $urandom};
    run_session(3, 1, 5, -1);
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(6, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_session(n, 2, -1, -1);
    end
  endtask

  task automatic test_full_depth();
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    run_session(DEPTH, 0, -1, -1);
    checks++;
    if (obs_addr.size() != DEPTH || obs_addr[DEPTH-1] !== 32'hFFC) begin errors++;
      $display("FAIL top_address: writes=%0d want %0d ending at 00000ffc", obs_addr.size(), DEPTH); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_overflow();
    test_back_to_back();
    test_reset_mid_load();
    test_start_mid_data();
    test_random();
    test_full_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
